// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM state type and defaults for the UART transmitter
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with occupancy level
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  // Counters carry one extra MSB so full and empty stay distinguishable.
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + (AW+1)'(1);
      if (do_pop)  rd_cnt <= rd_cnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART 8N1 transmitter with byte FIFO and valid/ready input
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int             CW        = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e       state, state_d;
  logic [CW-1:0]   baud_cnt, baud_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            tx_d;
  logic            baud_end;
  logic            pop;
  logic            full;
  logic            empty;
  logic [7:0]      fifo_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (tx_valid && tx_ready),
    .pop    (pop),
    .din    (tx_data),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );

  assign tx_ready = !full;
  assign busy     = (state != IDLE) || (fifo_level != '0);
  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_d   = state;
    baud_d    = baud_cnt + CW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: if (baud_end) begin
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (baud_end) begin
        baud_d  = '0;
        shift_d = {1'b0, shift[7:1]};
        if (bit_idx == 3'(DATA_BITS - 1)) begin
          bit_idx_d = '0;
          state_d   = STOP;
        end else begin
          bit_idx_d = bit_idx + 3'd1;
        end
      end
      STOP: if (baud_end) begin
        baud_d = '0;
        // bit_idx counts stop bits here; chain straight into the next frame
        if (bit_idx != STOP_LAST) begin
          bit_idx_d = bit_idx + 3'd1;
        end else if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the upcoming state so tx comes out of a flop.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule
